writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 m_valid  in  1  memory-stage result valid this cycle.
REQ-005 m_ready  out  1  unit accepts a result this cycle; transfer when m_valid && m_ready.
REQ-006 RegWriteM  in  1  result is to be written to a register.
REQ-007 MemtoRegM  in  1  result comes from data-memory read data, not the ALU.
REQ-008 WA3M  in  4  destination register index (R0-R15).
REQ-009 ALUResultM  in  32  ALU result.
REQ-010 ReadDataM  in  32  data-memory read data, valid only when mem_ack=1.
REQ-011 mem_ack  in  1  load data valid on ReadDataM.
REQ-012 WE3  out  1  register-file write enable, consumed by the Decode register file.
REQ-013 A3  out  4  register-file write address.
REQ-014 WD3  out  32  register-file write data.
REQ-015 PCSrcW  out  1  one-cycle PC redirect pulse for a write to R15.
REQ-016 PCTargetW  out  32  redirect target; valid while PCSrcW=1.
REQ-017 pending_mask  out  16  bit i=1 means a write to Ri is accepted and not yet retired.
REQ-018 mem_err  out  1  sticky load-timeout flag.

Function
REQ-019 FSM states: IDLE, WAIT_MEM, WRITE.
REQ-020 m_ready SHALL be 1 in IDLE and WRITE, and 0 in WAIT_MEM.
REQ-021 On accept, the unit SHALL capture RegWriteM, MemtoRegM, WA3M and ALUResultM.
- MemtoRegM=1 -> WAIT_MEM.
- MemtoRegM=0 -> WRITE.
REQ-022 WAIT_MEM with mem_ack=1 SHALL capture ReadDataM and go to WRITE; mem_ack outside WAIT_MEM SHALL be ignored.
REQ-023 WAIT_MEM SHALL count cycles with a 4-bit counter cleared on entry.
- After 15 cycles without mem_ack: set mem_err, drop the write, clear its pending bit, go to IDLE.
REQ-024 WRITE SHALL last exactly one cycle.
- No accept in that cycle -> IDLE.
- Accept in that cycle -> per REQ-021 (back-to-back).
REQ-025 In WRITE, with A3 = captured WA3M and WD3 = captured data:
- WE3 = RegWrite && A3 != 15.
- PCSrcW = RegWrite && A3 == 15, with PCTargetW = WD3.
REQ-026 Outside WRITE: WE3=0 and PCSrcW=0; A3 and WD3 SHALL hold their last values.
REQ-027 Latency: ALU result accepted in cycle N -> WE3 in cycle N+1; load with mem_ack in cycle K -> WE3 in cycle K+1.
REQ-028 pending_mask bit WA3M SHALL be set on an accept with RegWriteM=1, and cleared on that entry's WRITE cycle or timeout drop.
- Simultaneous clear and set of the same bit: set wins.
REQ-029 mem_err SHALL clear only on reset.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL go to IDLE with all of the following cleared:
- WE3=0, PCSrcW=0, A3=0, WD3=0, PCTargetW=0.
- pending_mask=0, mem_err=0, timeout counter=0.
REQ-031 Reset during WAIT_MEM or WRITE SHALL abandon the in-flight entry with no write and no redirect.

Structure
REQ-032 Shared package wb_pkg SHALL hold:
- the state enum {IDLE, WAIT_MEM, WRITE};
- REG_PC = 4'd15;
- MEM_TIMEOUT = 4'd15.
REQ-033 Sub-module wb_scoreboard SHALL implement the pending_mask set/clear logic (inputs: set_en, set_idx, clr_en, clr_idx).

Verification
REQ-034 ALU write: accept RegWriteM=1, MemtoRegM=0, WA3M=5, ALUResultM=666 -> next cycle WE3=1, A3=5, WD3=666; pending_mask[5] high for exactly one cycle.
REQ-035 Load: accept MemtoRegM=1, WA3M=4; mem_ack=1 with ReadDataM=777 three cycles later -> m_ready=0 meanwhile; then WE3=1, A3=4, WD3=777.
REQ-036 PC write: accept WA3M=15, ALUResultM=32 -> PCSrcW=1 and PCTargetW=32 for one cycle, WE3=0.
REQ-037 Timeout: load with no mem_ack -> after 15 cycles mem_err=1, no WE3 pulse, pending_mask[3]=0, m_ready=1.
REQ-038 Back-to-back: ALU writes to R4 (66) then R4 (777) on consecutive cycles -> WE3 for two consecutive cycles with WD3 66 then 777; pending_mask[4] stays 1 until after the second write.
REQ-039 Reset mid-load: rst_n=0 during WAIT_MEM -> no write, and all outputs at reset values.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage.
// Holds the FSM state enum, the PC register index and the load timeout.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  localparam logic [3:0] REG_PC      = 4'd15;
  localparam logic [3:0] MEM_TIMEOUT = 4'd15;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: tracks registers with an accepted, unretired write.
// Ports: clk, rst_n (sync, active-low), set_en/set_idx, clr_en/clr_idx,
// pending_mask (bit i = write to Ri outstanding).
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [3:0]  set_idx,
  input  logic        clr_en,
  input  logic [3:0]  clr_idx,
  output logic [15:0] pending_mask
);

  logic [15:0] r_mask;
  logic [15:0] w_set;
  logic [15:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (set_en) w_set[set_idx] = 1'b1;
    if (clr_en) w_clr[clr_idx] = 1'b1;
  end

  // Set is OR-ed in after the clear, so a new entry wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) r_mask <= '0;
    else        r_mask <= (r_mask & ~w_clr) | w_set;
  end

  assign pending_mask = r_mask;

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: memory->writeback stage; waits for load data with a
// timeout, drives the register-file write port and R15 redirects.
// Ports: clk, rst_n (sync, active-low); m_valid/m_ready handshake;
// RegWriteM, MemtoRegM, WA3M, ALUResultM, ReadDataM, mem_ack inputs;
// WE3/A3/WD3 RF write; PCSrcW/PCTargetW redirect; pending_mask; mem_err.
module writeback_unit
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [3:0]  WA3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ReadDataM,
  input  logic        mem_ack,
  output logic        WE3,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        PCSrcW,
  output logic [31:0] PCTargetW,
  output logic [15:0] pending_mask,
  output logic        mem_err
);

  wb_state_e   r_state;
  wb_state_e   w_next;

  // r_rw/r_wa3 describe the in-flight entry; r_a3/r_wd3 are the
  // RF port values, which only change on entry to WRITE.
  logic        r_rw;
  logic [3:0]  r_wa3;
  logic [3:0]  r_cnt;
  logic [3:0]  r_a3;
  logic [31:0] r_wd3;
  logic        r_err;

  logic        w_acc;
  logic        w_ack;
  logic        w_tmo;
  logic        w_wr;
  logic        w_clr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    m_ready = 1'b0;
    w_acc   = 1'b0;
    w_ack   = 1'b0;
    w_tmo   = 1'b0;
    w_wr    = 1'b0;
    unique case (r_state)
      IDLE, WRITE: begin
        m_ready = 1'b1;
        w_acc   = m_valid;
        w_wr    = (r_state == WRITE);
        if (m_valid) w_next = MemtoRegM ? WAIT_MEM : WRITE;
        else         w_next = IDLE;
      end
      WAIT_MEM: begin
        w_ack = mem_ack;
        // r_cnt holds completed waiting cycles; this is the last one.
        w_tmo = !mem_ack && (r_cnt == MEM_TIMEOUT - 4'd1);
        if (w_ack)      w_next = WRITE;
        else if (w_tmo) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rw  <= 1'b0;
      r_wa3 <= '0;
      r_cnt <= '0;
      r_a3  <= '0;
      r_wd3 <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rw  <= RegWriteM;
        r_wa3 <= WA3M;
        r_cnt <= '0;
        if (!MemtoRegM) begin
          r_a3  <= WA3M;
          r_wd3 <= ALUResultM;
        end
      end else if (w_ack) begin
        r_a3  <= r_wa3;
        r_wd3 <= ReadDataM;
      end else if (w_tmo) begin
        r_cnt <= '0;
        r_err <= 1'b1;
      end else if (r_state == WAIT_MEM) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign w_clr_en  = r_rw && (w_wr || w_tmo);

  assign WE3       = w_wr && r_rw && (r_a3 != REG_PC);
  assign PCSrcW    = w_wr && r_rw && (r_a3 == REG_PC);
  assign A3        = r_a3;
  assign WD3       = r_wd3;
  assign PCTargetW = r_wd3;
  assign mem_err   = r_err;

  wb_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en       (w_acc && RegWriteM),
    .set_idx      (WA3M),
    .clr_en       (w_clr_en),
    .clr_idx      (r_wa3),
    .pending_mask (pending_mask)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the writeback stage.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  logic        m_ready;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic        mem_ack;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        PCSrcW;
  logic [31:0] PCTargetW;
  logic [15:0] pending_mask;
  logic        mem_err;

  int n_chk = 0;
  int n_err = 0;

  writeback_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .RegWriteM    (RegWriteM),
    .MemtoRegM    (MemtoRegM),
    .WA3M         (WA3M),
    .ALUResultM   (ALUResultM),
    .ReadDataM    (ReadDataM),
    .mem_ack      (mem_ack),
    .WE3          (WE3),
    .A3           (A3),
    .WD3          (WD3),
    .PCSrcW       (PCSrcW),
    .PCTargetW    (PCTargetW),
    .pending_mask (pending_mask),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  // Model: an outstanding load (ld_*) and the entry writing this cycle.
  bit          live = 0;
  bit          ld_on;
  bit          ld_rw;
  logic [3:0]  ld_idx;
  int          ld_wait;
  bit          wr_on;
  bit          wr_rw;
  logic [3:0]  wr_idx;
  logic [3:0]  e_a3;
  logic [31:0] e_wd3;
  bit          e_err;
  logic [15:0] e_pend;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
               $time);
    end
  endfunction

  task automatic model_update();
    bit          acc;
    bit          nw;
    bit          nrw;
    logic [3:0]  nidx;
    logic [31:0] ndat;
    if (!rst_n) begin
      live = 1; ld_on = 0; ld_rw = 0; ld_idx = 0; ld_wait = 0;
      wr_on = 0; wr_rw = 0; wr_idx = 0;
      e_a3 = 0; e_wd3 = 0; e_err = 0; e_pend = 0;
      return;
    end
    acc  = m_valid && !ld_on;
    nw   = 0;
    nrw  = 0;
    nidx = 0;
    ndat = 0;
    if (wr_on && wr_rw) e_pend[wr_idx] = 1'b0;
    if (ld_on) begin
      if (mem_ack) begin
        nw = 1; nrw = ld_rw; nidx = ld_idx; ndat = ReadDataM;
        ld_on = 0;
      end else begin
        ld_wait++;
        if (ld_wait == 15) begin
          e_err = 1;
          if (ld_rw) e_pend[ld_idx] = 1'b0;
          ld_on = 0;
        end
      end
    end
    if (acc) begin
      if (RegWriteM) e_pend[WA3M] = 1'b1;
      if (MemtoRegM) begin
        ld_on = 1; ld_wait = 0; ld_rw = RegWriteM; ld_idx = WA3M;
      end else begin
        nw = 1; nrw = RegWriteM; nidx = WA3M; ndat = ALUResultM;
      end
    end
    wr_on  = nw;
    wr_rw  = nrw;
    wr_idx = nidx;
    if (nw) begin
      e_a3  = nidx;
      e_wd3 = ndat;
    end
  endtask

  // Compare process: every cycle once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        chk("m_ready", m_ready, !ld_on);
        chk("WE3", WE3, wr_on && wr_rw && wr_idx != 4'd15);
        chk("PCSrcW", PCSrcW, wr_on && wr_rw && wr_idx == 4'd15);
        if (wr_on && wr_rw && wr_idx == 4'd15)
          chk("PCTargetW", PCTargetW, e_wd3);
        chk("A3", A3, e_a3);
        chk("WD3", WD3, e_wd3);
        chk("pending_mask", pending_mask, e_pend);
        chk("mem_err", mem_err, e_err);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m_valid = 0; RegWriteM = 0; MemtoRegM = 0; WA3M = 0;
    ALUResultM = 0; ReadDataM = 0; mem_ack = 0;
  endtask

  task automatic put(bit rw, bit ld, logic [3:0] idx, logic [31:0] d);
    m_valid = 1; RegWriteM = rw; MemtoRegM = ld; WA3M = idx;
    ALUResultM = d;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    idle_in();
    do_reset();
    chk("rst_WE3", WE3, 0);
    chk("rst_A3", A3, 0);
    chk("rst_WD3", WD3, 0);
    chk("rst_PCTargetW", PCTargetW, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_m_ready", m_ready, 1);

    // ALU write to R5
    put(1, 0, 4'd5, 32'd666);
    step();
    idle_in();
    chk("alu_WE3", WE3, 1);
    chk("alu_A3", A3, 5);
    chk("alu_WD3", WD3, 666);
    chk("alu_pend5", pending_mask[5], 1);
    step();
    chk("alu_WE3_off", WE3, 0);
    chk("alu_pend5_off", pending_mask[5], 0);

    // Load to R4 with data three cycles after accept
    put(1, 1, 4'd4, 32'd1);
    step();
    idle_in();
    chk("ld_ready1", m_ready, 0);
    step();
    chk("ld_ready2", m_ready, 0);
    step();
    chk("ld_ready3", m_ready, 0);
    mem_ack = 1;
    ReadDataM = 32'd777;
    step();
    idle_in();
    chk("ld_WE3", WE3, 1);
    chk("ld_A3", A3, 4);
    chk("ld_WD3", WD3, 777);
    chk("ld_ready4", m_ready, 1);
    step();

    // PC write
    put(1, 0, 4'd15, 32'd32);
    step();
    idle_in();
    chk("pc_PCSrcW", PCSrcW, 1);
    chk("pc_target", PCTargetW, 32);
    chk("pc_WE3", WE3, 0);
    step();
    chk("pc_PCSrcW_off", PCSrcW, 0);

    // Load timeout on R3
    put(1, 1, 4'd3, 32'd9);
    step();
    idle_in();
    for (int i = 0; i < 14; i++) step();
    chk("tmo_err_early", mem_err, 0);
    chk("tmo_pend3_early", pending_mask[3], 1);
    step();
    chk("tmo_err", mem_err, 1);
    chk("tmo_pend3", pending_mask[3], 0);
    chk("tmo_ready", m_ready, 1);
    chk("tmo_WE3", WE3, 0);
    mem_ack = 1;
    ReadDataM = 32'hdead;
    step();
    idle_in();
    chk("stray_ack_WE3", WE3, 0);

    // Back-to-back writes to R4
    put(1, 0, 4'd4, 32'd66);
    step();
    put(1, 0, 4'd4, 32'd777);
    chk("b2b_WE3a", WE3, 1);
    chk("b2b_WD3a", WD3, 66);
    chk("b2b_pend4a", pending_mask[4], 1);
    step();
    idle_in();
    chk("b2b_WE3b", WE3, 1);
    chk("b2b_WD3b", WD3, 777);
    chk("b2b_pend4b", pending_mask[4], 1);
    step();
    chk("b2b_WE3c", WE3, 0);
    chk("b2b_pend4c", pending_mask[4], 0);

    // Reset during a load
    put(1, 1, 4'd7, 32'd5);
    step();
    idle_in();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rmid_WE3", WE3, 0);
    chk("rmid_PCSrcW", PCSrcW, 0);
    chk("rmid_A3", A3, 0);
    chk("rmid_WD3", WD3, 0);
    chk("rmid_PCTargetW", PCTargetW, 0);
    chk("rmid_pending", pending_mask, 0);
    chk("rmid_mem_err", mem_err, 0);
    chk("rmid_ready", m_ready, 1);
    mem_ack = 1;
    ReadDataM = 32'h55;
    step();
    idle_in();
    chk("rmid_noWE3", WE3, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      m_valid    = ($urandom % 3) != 0;
      RegWriteM  = ($urandom % 4) != 0;
      MemtoRegM  = ($urandom % 3) == 0;
      WA3M       = 4'($urandom);
      ALUResultM = $urandom;
      ReadDataM  = $urandom;
      mem_ack    = ($urandom % 5) == 0;
      rst_n      = ($urandom % 400) != 0;
      step();
    end
    rst_n = 1;
    idle_in();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
